// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the pipelined MIPS core. The memory
// stage issues load/store requests over a valid/ready channel. A one-cycle
// response strobe follows acceptance after LATENCY cycles. The hazard unit
// stalls the pipeline while req_ready is low.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2), default 64
//   LATENCY      cycles from acceptance to resp_valid (1..15), default 2
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   req_valid   request present
//   req_ready   responder can accept this cycle (registered state decode)
//   req_we      1 = store, 0 = load
//   req_addr    byte address; word index = req_addr[31:2] mod DEPTH_WORDS
//   req_wdata   store data
//   req_be      byte enables (only when DMEM_BYTE_EN is defined)
//   resp_valid  one-cycle response strobe
//   resp_rdata  load data; 0 for stores and misaligned requests
//   resp_err    1 = misaligned request (valid with resp_valid)
//
// Optional feature macro: DMEM_BYTE_EN (adds req_be and enables partial stores).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the registered state,
// never on req_valid. Request fields are ignored when no transfer occurs.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   // state is the observation point for FSM checkers
   state_t state, state_nxt;

   logic [3:0]       cnt;
   logic             lat_we;
   logic             lat_mis;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_wdata;
   logic [3:0]       lat_be;

   logic [31:0]      mem [DEPTH_WORDS];

   logic [3:0]       in_be;
   logic             accept;
   logic             enter_resp;
   logic             in_idle;
   logic             op_we;
   logic             op_mis;
   logic [IDX_W-1:0] op_idx;
   logic [31:0]      op_wdata;
   logic [3:0]       op_be;

   // Address bits above the index simply alias
   logic unused_addr;
   assign unused_addr = ^req_addr[31:IDX_W+2];

`ifdef DMEM_BYTE_EN
   assign in_be = req_be;
`else
   assign in_be = 4'hF;
`endif

   assign in_idle    = (state == S_IDLE);
   assign accept     = in_idle && req_valid;
   assign enter_resp = (accept && (LATENCY == 1)) ||
                       ((state == S_WAIT) && (cnt == 4'd0));

   // With LATENCY=1 the array operation happens on the accept edge itself,
   // so the operands come straight from the request instead of the latches.
   assign op_we    = in_idle ? req_we                   : lat_we;
   assign op_mis   = in_idle ? (req_addr[1:0] != 2'b00) : lat_mis;
   assign op_idx   = in_idle ? req_addr[IDX_W+1:2]      : lat_idx;
   assign op_wdata = in_idle ? req_wdata                : lat_wdata;
   assign op_be    = in_idle ? in_be                    : lat_be;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready  = (state == S_IDLE);
      resp_valid = (state == S_RESP);
   end

   // ---------------- request latch, counter, response data ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 4'd0;
         lat_we     <= 1'b0;
         lat_mis    <= 1'b0;
         lat_idx    <= '0;
         lat_wdata  <= 32'd0;
         lat_be     <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            lat_we    <= req_we;
            lat_mis   <= (req_addr[1:0] != 2'b00);
            lat_idx   <= req_addr[IDX_W+1:2];
            lat_wdata <= req_wdata;
            lat_be    <= in_be;
            cnt       <= CNT_INIT;
         end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err   <= op_mis;
            resp_rdata <= (!op_we && !op_mis) ? mem[op_idx] : 32'd0;
         end
      end
   end

   // ---------------- storage array (not reset) ----------------
   // The rst term makes a reset coinciding with the commit edge win.
   always_ff @(posedge clk) begin
      if (rst && enter_resp && op_we && !op_mis) begin
         for (int b = 0; b < 4; b++) begin
            if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined MIPS core. It answers load/store requests issued by the memory stage over a valid/ready request channel and returns a one-cycle response pulse after a fixed latency. It replaces the single-cycle combinational data memory so that the hazard unit can stall the pipeline while `req_ready` is low.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words in the array; must be a power of two, at least 2.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`; legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  memory stage presents a request.
- `req_ready`  output  1  responder can accept a request this cycle.
- `req_we`  input  1  1 = store, 0 = load.
- `req_addr`  input  32  byte address; word index = `req_addr[31:2]` modulo `DEPTH_WORDS`.
- `req_wdata`  input  32  store data.
- `req_be`  input  4  byte enables; present only with `DMEM_BYTE_EN`.
- `resp_valid`  output  1  one-cycle response strobe.
- `resp_rdata`  output  32  load data; 0 for stores and errors.
- `resp_err`  output  1  valid with `resp_valid`; 1 = misaligned request.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_we`, word index, `req_wdata`, (`req_be`), and misalign flag (`req_addr[1:0]!=0`). If `LATENCY`=1 go to RESP; else load the down-counter with `LATENCY-2` and go to WAIT.
- WAIT: `req_ready`=0; count down each cycle; when the counter is 0, go to RESP.
- The array operation happens on the edge that enters RESP: loads capture `mem[idx]` into `resp_rdata`; stores write `mem[idx]` (all bytes, or enabled bytes under `DMEM_BYTE_EN`). Misaligned requests neither read nor write.
- RESP: `resp_valid`=1 for exactly one cycle, `req_ready`=0; next state IDLE. `resp_rdata` holds its value until the next response.
- Inputs other than `req_valid` are ignored outside IDLE; a request held through WAIT/RESP is not accepted until the next IDLE cycle.
- Address wrap: indices at or above `DEPTH_WORDS` alias modulo depth; for example, with depth 64, byte address 0x100 maps to word 0.
- Array contents are not reset.

## Timing
- Accept at edge T; `resp_valid` high during cycle T+`LATENCY`; `req_ready` high again at T+`LATENCY`+1.
- Throughput: one request per `LATENCY`+1 cycles.
- A load following a store to the same word returns the stored data.
- Reset assertion at any time: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, counter 0.
- Reset during WAIT discards the pending request; a pending store is not committed.
- Reset on the edge that would enter RESP takes priority; no commit occurs.
- `req_ready` is a registered state decode, with no combinational path from `req_valid`.

## Configuration
- `DMEM_BYTE_EN` defined: `req_be` port exists. Stores write only the bytes whose enable is set, where bit i selects `wdata[8i+7:8i]`. Loads ignore `req_be` and return the full word. A store with `req_be`=0 is a legal no-op and still produces a response.
- `DMEM_BYTE_EN` undefined: no `req_be` port; every store writes all 32 bits.

## Test plan
- Reset then idle, `LATENCY`=2 -> `req_ready`=1, `resp_valid`=0, `resp_rdata`=0.
- Store 0xDEADBEEF @0x10, then load @0x10, `LATENCY`=2 -> store response `resp_rdata`=0, `resp_err`=0; load `resp_valid` 2 cycles after accept with 0xDEADBEEF; `req_ready` low for 2 cycles after each accept.
- Store 0x12345678 @0x0, load @0x100, depth 64 -> 0x12345678 (wrap). Load @0x3 -> `resp_err`=1, `resp_rdata`=0, memory unchanged.
- `LATENCY`=1 with back-to-back `req_valid` -> response the cycle after accept; accepts spaced exactly 2 cycles apart.
- Store 0xAAAAAAAA @0x20 with `LATENCY`=4; assert `rst` low 2 cycles after accept; then load @0x20 -> prior value (not 0xAAAAAAAA); all outputs at reset values during reset.
- With `DMEM_BYTE_EN`: store 0xFFFFFFFF (`be`=0xF), then 0x00000000 (`be`=0x5) @0x8, then load -> 0xFF00FF00.
